ps2_receiver: RTL and testbench
===============================

PS2_RECEIVER -- requirements
Module: ps2_receiver

Interface
REQ-001 The block SHALL have parameter FILTER_LEN, default 8: consecutive equal samples required before the filtered PS/2 clock or data changes value.
REQ-002 The block SHALL have parameter TIMEOUT, default 5000: maximum cycles allowed between falling edges inside a frame.
REQ-003 The block SHALL have port Clock  input  1  system clock; one clock; all logic on its rising edge.
REQ-004 The block SHALL have port Reset  input  1  reset; synchronous, active-high.
REQ-005 The block SHALL have port iPS2_CLK  input  1  raw keyboard clock, asynchronous.
REQ-006 The block SHALL have port iPS2_DATA  input  1  raw keyboard data, asynchronous.
REQ-007 The block SHALL have port oScanCode  output  8  last accepted scan code, held until the next accepted code.
REQ-008 The block SHALL have port oValid  output  1  one-cycle pulse marking a new oScanCode.
REQ-009 The block SHALL have port oBreak  output  1  key-release qualifier, valid while oValid=1.
REQ-010 The block SHALL have port oParityError  output  1  one-cycle pulse on an odd-parity failure.
REQ-011 The block SHALL have port oFrameError  output  1  one-cycle pulse on a bad stop bit or a timeout.

Function
REQ-012 Each input SHALL pass through a 2-flop synchronizer, then a filter that changes its output only after FILTER_LEN consecutive identical synchronized samples.
REQ-013 A falling edge SHALL be a filtered-clock transition 1->0 detected against its registered previous value; data SHALL be sampled from the filtered data in that same cycle.
REQ-014 The FSM SHALL have four states: IDLE, DATA, PARITY, STOP.
REQ-015 IDLE: edge with data=0 -> DATA, bit count cleared; edge with data=1 -> ignored, stay in IDLE.
REQ-016 DATA: each edge shifts one bit in, LSB first; after the 8th bit -> PARITY.
REQ-017 PARITY: on the edge, the 8 data bits plus the parity bit SHALL contain an odd number of ones, else a parity error is flagged; then -> STOP.
REQ-018 STOP: on the edge -> IDLE; data=0 -> oFrameError pulse; data=1 with a parity error -> oParityError pulse; otherwise the frame is accepted.
REQ-019 On an accepted code 0xF0: set the internal break flag; no oValid.
REQ-020 On any other accepted code: oScanCode=code, oValid=1 for exactly one cycle, oBreak=break flag, then clear the break flag.
REQ-021 Errored frames SHALL leave the break flag and oScanCode unchanged.
REQ-022 All pulses SHALL be asserted in the cycle after the stop-bit edge is detected.
REQ-023 Latency from the raw stop-bit falling edge to oValid SHALL be at most FILTER_LEN+4 cycles.
REQ-024 Timeout counter: it SHALL clear on every edge and in IDLE, and count in DATA/PARITY/STOP; on reaching TIMEOUT, the FSM SHALL go to IDLE and pulse oFrameError once.
REQ-025 Timeout counter width SHALL be ceil(log2(TIMEOUT+1)); it SHALL saturate rather than wrap.
REQ-026 At most one of oValid, oParityError and oFrameError SHALL be high in any cycle.

Reset
REQ-027 Reset=1 at a rising Clock edge SHALL force: state=IDLE; bit count, timeout counter and break flag = 0; synchronizer and filter flops = 1 (bus idle).
REQ-028 Reset SHALL force outputs: oScanCode=0x00; oValid, oBreak, oParityError and oFrameError = 0.
REQ-029 Reset SHALL take priority over every other event, including a mid-frame edge.
REQ-030 A partial frame interrupted by reset SHALL produce no pulse.

Verification
REQ-031 Frame 0x1D, parity 1, stop 1 -> single oValid; oScanCode=0x1D; oBreak=0; no error pulses.
REQ-032 Frame 0xF0, then frame 0x1D -> exactly one oValid, with oScanCode=0x1D and oBreak=1; the next frame 0x1C -> oBreak=0.
REQ-033 Frame 0x1C with parity 0 -> one oParityError pulse, no oValid; oScanCode keeps its previous value.
REQ-034 Frame 0x23 with stop 0 -> one oFrameError pulse; a stall of TIMEOUT+10 cycles after 4 data bits -> one oFrameError pulse, after which a clean 0x23 frame is received with oValid=1.
REQ-035 FILTER_LEN=8: a 3-cycle low glitch on iPS2_CLK while in IDLE -> no state change and no pulses.
REQ-036 Reset asserted after 5 data bits, then a clean frame 0x2B -> oValid=1 with oScanCode=0x2B and no error pulses.

Source files
------------

// File: rtl/ps2_receiver.sv
// PS/2 keyboard receiver: synchronises and de-glitches the raw PS/2 clock and
// data lines, deframes 11-bit frames (start, 8 data LSB first, odd parity,
// stop), tracks the 0xF0 break prefix and reports codes and frame errors.
module ps2_receiver #(
  parameter int unsigned FILTER_LEN = 8,
  parameter int unsigned TIMEOUT    = 5000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iPS2_CLK,
  input  logic       iPS2_DATA,
  output logic [7:0] oScanCode,
  output logic       oValid,
  output logic       oBreak,
  output logic       oParityError,
  output logic       oFrameError
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);
  localparam logic [FW-1:0] FMAX = FW'(FILTER_LEN - 1);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_t;

  // Channel 0 is the PS/2 clock, channel 1 is the PS/2 data.
  logic [1:0]    sync1_q, sync2_q, filt_q;
  logic [FW-1:0] fcnt_q [2];
  logic          clk_prev_q;
  logic          fall;

  state_t        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_err_q, par_err_d;
  logic          brk_q, brk_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          tmo_hit;
  logic [7:0]    scan_q, scan_d;
  logic          valid_q, valid_d;
  logic          brk_out_q, brk_out_d;
  logic          perr_q, perr_d;
  logic          ferr_q, ferr_d;

  // Input synchronisers and run-length filters; idle bus level is high.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      sync1_q    <= 2'b11;
      sync2_q    <= 2'b11;
      filt_q     <= 2'b11;
      clk_prev_q <= 1'b1;
      for (int i = 0; i < 2; i++) fcnt_q[i] <= '0;
    end else begin
      sync1_q    <= {iPS2_DATA, iPS2_CLK};
      sync2_q    <= sync1_q;
      clk_prev_q <= filt_q[0];
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == filt_q[i]) begin
          fcnt_q[i] <= '0;
        end else if (fcnt_q[i] == FMAX) begin
          // FILTER_LEN consecutive differing samples: accept the new level.
          filt_q[i] <= sync2_q[i];
          fcnt_q[i] <= '0;
        end else begin
          fcnt_q[i] <= fcnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign fall    = clk_prev_q & ~filt_q[0];
  assign tmo_hit = (state_q != StIdle) && (tmo_q == TMAX);

  // Frame state, shift register, break flag and registered output pulses.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_err_q <= 1'b0;
      brk_q     <= 1'b0;
      tmo_q     <= '0;
      scan_q    <= '0;
      valid_q   <= 1'b0;
      brk_out_q <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_err_q <= par_err_d;
      brk_q     <= brk_d;
      tmo_q     <= tmo_d;
      scan_q    <= scan_d;
      valid_q   <= valid_d;
      brk_out_q <= brk_out_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
    end
  end

  // Next-state decode: a timeout aborts the frame ahead of any coincident edge.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_err_d = par_err_q;
    brk_d     = brk_q;
    scan_d    = scan_q;
    valid_d   = 1'b0;
    brk_out_d = 1'b0;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;

    if (state_q == StIdle || fall) begin
      tmo_d = '0;
    end else if (tmo_q != TMAX) begin
      tmo_d = tmo_q + 1'b1;
    end else begin
      tmo_d = tmo_q;
    end

    if (tmo_hit) begin
      state_d = StIdle;
      ferr_d  = 1'b1;
    end else if (fall) begin
      unique case (state_q)
        StIdle: begin
          if (!filt_q[1]) begin
            state_d   = StData;
            bit_cnt_d = '0;
          end
        end
        StData: begin
          shift_d   = {filt_q[1], shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_d = StParity;
        end
        StParity: begin
          // Odd parity: data plus parity bit must XOR to one.
          par_err_d = ~(^shift_q ^ filt_q[1]);
          state_d   = StStop;
        end
        StStop: begin
          state_d = StIdle;
          if (!filt_q[1]) begin
            ferr_d = 1'b1;
          end else if (par_err_q) begin
            perr_d = 1'b1;
          end else if (shift_q == 8'hF0) begin
            brk_d = 1'b1;
          end else begin
            scan_d    = shift_q;
            valid_d   = 1'b1;
            brk_out_d = brk_q;
            brk_d     = 1'b0;
          end
        end
      endcase
    end
  end

  assign oScanCode    = scan_q;
  assign oValid       = valid_q;
  assign oBreak       = brk_out_q;
  assign oParityError = perr_q;
  assign oFrameError  = ferr_q;

endmodule

// File: tb/tb_ps2_receiver.sv
// Bench for ps2_receiver: directed and random PS/2 frames, a frame-level
// reference model filling an expectation queue, and a monitor that pops and
// compares whenever the receiver raises a pulse.
module tb_ps2_receiver;

  localparam int unsigned FILTER_LEN = 8;
  localparam int unsigned TIMEOUT    = 1000;
  localparam int          HALF       = 20;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] scan_code;
  logic       valid, brk, perr, ferr;

  ps2_receiver #(
    .FILTER_LEN(FILTER_LEN),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .iPS2_CLK    (ps2_clk),
    .iPS2_DATA   (ps2_data),
    .oScanCode   (scan_code),
    .oValid      (valid),
    .oBreak      (brk),
    .oParityError(perr),
    .oFrameError (ferr)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    int         kind;  // 0 code, 1 parity error, 2 frame error
    logic [7:0] code;
    logic       brk;
  } exp_t;

  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  int         cyc      = 0;
  int         last_fall = 0;
  logic       model_brk = 1'b0;
  logic [7:0] model_code = 8'h00;

  always @(posedge Clock) cyc++;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    tick(HALF);
    ps2_clk   = 1'b0;
    last_fall = cyc;
    tick(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) send_bit(f[i]);
    ps2_data = 1'b1;
  endtask

  // Frame-level reference: decides the outcome from the frame rules alone.
  task automatic send_frame(input logic [7:0] code, input logic par, input logic stop);
    exp_t e;
    e.code = code;
    e.brk  = 1'b0;
    if (!stop) begin
      e.kind = 2;
      exp_q.push_back(e);
    end else if ($countones({code, par}) % 2 == 0) begin
      e.kind = 1;
      exp_q.push_back(e);
    end else if (code == 8'hF0) begin
      model_brk = 1'b1;
    end else begin
      e.kind = 0;
      e.brk  = model_brk;
      exp_q.push_back(e);
      model_code = code;
      model_brk  = 1'b0;
    end
    send_bits({stop, par, code, 1'b0}, 11);
    tick(40);
    check("scan_code_held", int'(scan_code), int'(model_code));
  endtask

  function automatic logic odd_par(input logic [7:0] c);
    return ~^c;
  endfunction

  // Monitor: every pulse must match the head of the expectation queue.
  always @(negedge Clock) begin
    exp_t e;
    int   kind;
    if (!Reset && (valid || perr || ferr)) begin
      check("one_hot_pulse", $countones({valid, perr, ferr}), 1);
      kind = valid ? 0 : (perr ? 1 : 2);
      check("pulse_expected", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pulse_kind", kind, e.kind);
        if (e.kind == 0 && kind == 0) begin
          check("scan_code", int'(scan_code), int'(e.code));
          check("break_flag", int'(brk), int'(e.brk));
          check("latency_ok", int'((cyc - last_fall) <= int'(FILTER_LEN) + 4), 1);
        end
      end
    end
  end

  initial begin
    logic [7:0] c;
    logic       p, s;
    Reset    = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    tick(4);
    check("rst_scan", int'(scan_code), 0);
    check("rst_pulses", int'({valid, brk, perr, ferr}), 0);
    Reset = 1'b0;
    tick(5);

    send_frame(8'h1D, 1'b1, 1'b1);
    send_frame(8'hF0, odd_par(8'hF0), 1'b1);
    send_frame(8'h1D, 1'b1, 1'b1);
    send_frame(8'h1C, odd_par(8'h1C), 1'b1);
    // 0x1C with a deliberately wrong parity bit.
    send_frame(8'h1C, ~odd_par(8'h1C), 1'b1);
    send_frame(8'h23, odd_par(8'h23), 1'b0);

    // Stall after start plus four data bits: one timeout frame error.
    begin
      exp_t e;
      e.kind = 2; e.code = 8'h00; e.brk = 1'b0;
      exp_q.push_back(e);
      c = 8'h23;
      send_bits({1'b1, odd_par(c), c, 1'b0}, 5);
      tick(TIMEOUT + 10);
    end
    send_frame(8'h23, odd_par(8'h23), 1'b1);

    // Short low glitch on the clock while idle must be filtered out.
    ps2_clk = 1'b0;
    tick(3);
    ps2_clk = 1'b1;
    tick(40);
    check("glitch_no_pulse", exp_q.size(), 0);
    send_frame(8'h2B, odd_par(8'h2B), 1'b1);

    // Break pending, then reset mid-frame: partial frame and flag discarded.
    send_frame(8'hF0, odd_par(8'hF0), 1'b1);
    c = 8'h55;
    send_bits({1'b1, odd_par(c), c, 1'b0}, 6);
    Reset = 1'b1;
    tick(3);
    Reset      = 1'b0;
    model_brk  = 1'b0;
    model_code = 8'h00;
    check("midrst_scan", int'(scan_code), 0);
    tick(5);
    send_frame(8'h2B, odd_par(8'h2B), 1'b1);

    for (int i = 0; i < 24; i++) begin
      c = ($urandom_range(0, 3) == 0) ? 8'hF0 : 8'($urandom);
      p = ($urandom_range(0, 4) == 0) ? ~odd_par(c) : odd_par(c);
      s = ($urandom_range(0, 7) == 0) ? 1'b0 : 1'b1;
      send_frame(c, p, s);
    end

    tick(100);
    check("all_expected_seen", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
